i2c_target_regfile: RTL and testbench

Synthesizable I2C target (slave) that answers the master side of the i2c_avip bench on the shared SCL/SDA bus.
- Oversamples SCL/SDA on the system clock, detects START/STOP, matches a 7-bit address and ACKs.
- Write transfer: register-address byte, then data bytes into an internal register file with auto-increment.
- Read transfer: returns register contents MSB first.

---
 rtl/i2c_target_regfile.sv | 334 +++++++++++++++++++++++++++++++++
 tb/tb_i2c_target_regfile.sv | 311 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/i2c_target_regfile.sv
// ---------------------------------------------------------------------------
// i2c_target_regfile
//
// I2C target with a small register file. SCL and SDA are oversampled on pclk,
// START/STOP are detected from the synchronized levels, a 7-bit address is
// matched and ACKed. A write transfer supplies a register pointer followed by
// data bytes (pointer auto-increments). A read transfer returns register
// contents MSB first, continuing while the controller ACKs.
//
// Optional build macro: I2C_TARGET_CLOCK_STRETCH_EN
//   When defined, SCL is held low for STRETCH_CYCLES pclk cycles after the SCL
//   fall that ends every ACK bit. When undefined, scl_oe is constant low.
//
// Ports:
//   pclk       system clock (at least 8x the SCL frequency)
//   areset     asynchronous active-low reset
//   scl_i      SCL bus level
//   sda_i      SDA bus level
//   sda_oe     1 = pull SDA low (open drain)
//   scl_oe     1 = pull SCL low (clock stretch)
//   busy       high from START through STOP
//   wr_strobe  one-cycle pulse per committed write byte
//   wr_addr    register index of the committed byte
//   wr_data    committed byte
// ---------------------------------------------------------------------------
module i2c_target_regfile #(
  parameter logic [6:0] SLAVE_ADDRESS          = 7'h68,
  parameter int         DATA_LENGTH            = 8,
  parameter int         REGISTER_ADDRESS_WIDTH = 8,
  parameter int         NO_OF_REGS             = 16,
  parameter int         STRETCH_CYCLES         = 4
) (
  input  logic                              pclk,
  input  logic                              areset,
  input  logic                              scl_i,
  input  logic                              sda_i,
  output logic                              sda_oe,
  output logic                              scl_oe,
  output logic                              busy,
  output logic                              wr_strobe,
  output logic [REGISTER_ADDRESS_WIDTH-1:0] wr_addr,
  output logic [DATA_LENGTH-1:0]            wr_data
);

  localparam int RAW   = REGISTER_ADDRESS_WIDTH;
  localparam int DL    = DATA_LENGTH;
  // Receive shifter must hold an 8-bit address/pointer byte or a data word.
  localparam int RX_W  = (DL > 8) ? DL : 8;
  localparam int CNT_W = $clog2(RX_W + 1);
  localparam int IDX_W = (NO_OF_REGS > 1) ? $clog2(NO_OF_REGS) : 1;

  localparam logic [CNT_W-1:0] BYTE_BITS = CNT_W'(8);
  localparam logic [CNT_W-1:0] DATA_BITS = DATA_LENGTH[CNT_W-1:0];
  localparam logic [RAW:0]     NREGS     = NO_OF_REGS[RAW:0];

  typedef enum logic [3:0] {
    IDLE,
    ADDR,
    ADDR_ACK,
    REG_ADDR,
    REG_ACK,
    WR_DATA,
    WR_ACK,
    RD_DATA,
    RD_ACK
  } state_e;

  // ------------------------------------------------------------------------
  // Synchronizers and edge detection. Flops reset to the idle bus level so
  // that leaving reset on an idle bus produces no spurious edge.
  // ------------------------------------------------------------------------
  logic scl_s1_q, scl_s2_q, scl_d1_q;
  logic sda_s1_q, sda_s2_q, sda_d1_q;

  always_ff @(posedge pclk or negedge areset) begin
    if (!areset) begin
      scl_s1_q <= 1'b1;
      scl_s2_q <= 1'b1;
      scl_d1_q <= 1'b1;
      sda_s1_q <= 1'b1;
      sda_s2_q <= 1'b1;
      sda_d1_q <= 1'b1;
    end else begin
      scl_s1_q <= scl_i;
      scl_s2_q <= scl_s1_q;
      scl_d1_q <= scl_s2_q;
      sda_s1_q <= sda_i;
      sda_s2_q <= sda_s1_q;
      sda_d1_q <= sda_s2_q;
    end
  end

  logic scl_rise, scl_fall, start_det, stop_det;
  logic scl_rise_e, scl_fall_e, stretching;

  assign scl_rise  = scl_s2_q & ~scl_d1_q;
  assign scl_fall  = ~scl_s2_q & scl_d1_q;
  // SCL must be high in both compared samples so a data change racing an
  // SCL edge is never taken for START/STOP.
  assign start_det = scl_s2_q & scl_d1_q & sda_d1_q & ~sda_s2_q;
  assign stop_det  = scl_s2_q & scl_d1_q & ~sda_d1_q & sda_s2_q;

  // SCL edges are ignored while this target is holding SCL low.
  assign scl_rise_e = scl_rise & ~stretching;
  assign scl_fall_e = scl_fall & ~stretching;

  // ------------------------------------------------------------------------
  // State and datapath registers
  // ------------------------------------------------------------------------
  state_e                 state_q, state_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic [RX_W-1:0]        rx_q, rx_d;
  logic [DL-1:0]          tx_q, tx_d;
  logic [RAW-1:0]         ptr_q, ptr_d;
  logic                   rw_q, rw_d;
  logic                   sda_oe_q, sda_oe_d;
  logic                   busy_q, busy_d;
  logic                   wr_strobe_q, wr_strobe_d;
  logic [RAW-1:0]         wr_addr_q, wr_addr_d;
  logic [DL-1:0]          wr_data_q, wr_data_d;
  logic                   reg_we;

  logic [DL-1:0]          regs_q [NO_OF_REGS];
  logic [IDX_W-1:0]       ptr_idx;
  logic                   in_range;
  logic [DL-1:0]          rd_val;

  assign ptr_idx  = ptr_q[IDX_W-1:0];
  assign in_range = ({1'b0, ptr_q} < NREGS);
  // Out-of-range reads return all-ones (undriven bus value).
  assign rd_val   = in_range ? regs_q[ptr_idx] : '1;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    rx_d        = rx_q;
    tx_d        = tx_q;
    ptr_d       = ptr_q;
    rw_d        = rw_q;
    sda_oe_d    = sda_oe_q;
    busy_d      = busy_q;
    wr_strobe_d = 1'b0;
    wr_addr_d   = wr_addr_q;
    wr_data_d   = wr_data_q;
    reg_we      = 1'b0;

    if (start_det) begin
      state_d  = ADDR;
      cnt_d    = '0;
      busy_d   = 1'b1;
      sda_oe_d = 1'b0;
    end else if (stop_det) begin
      state_d  = IDLE;
      busy_d   = 1'b0;
      sda_oe_d = 1'b0;
    end else begin
      case (state_q)
        ADDR, REG_ADDR, WR_DATA: begin
          if (scl_rise_e && cnt_q != ((state_q == WR_DATA) ? DATA_BITS : BYTE_BITS)) begin
            rx_d  = {rx_q[RX_W-2:0], sda_s2_q};
            cnt_d = cnt_q + 1'b1;
          end else if (scl_fall_e && cnt_q == ((state_q == WR_DATA) ? DATA_BITS : BYTE_BITS)) begin
            // Byte complete; the fall after its last bit opens the ACK slot.
            cnt_d = '0;
            if (state_q == ADDR) begin
              if (rx_q[7:1] == SLAVE_ADDRESS) begin
                state_d  = ADDR_ACK;
                rw_d     = rx_q[0];
                sda_oe_d = 1'b1;
              end else begin
                state_d  = IDLE;   // not addressed: stay quiet, busy until STOP
              end
            end else if (state_q == REG_ADDR) begin
              ptr_d    = RAW'(rx_q[7:0]);
              state_d  = REG_ACK;
              sda_oe_d = 1'b1;
            end else begin
              if (in_range) begin
                reg_we      = 1'b1;
                wr_strobe_d = 1'b1;
                wr_addr_d   = ptr_q;
                wr_data_d   = rx_q[DL-1:0];
              end
              ptr_d    = ptr_q + 1'b1;
              state_d  = WR_ACK;
              sda_oe_d = 1'b1;
            end
          end
        end

        ADDR_ACK: begin
          if (scl_fall_e) begin
            cnt_d = '0;
            if (rw_q) begin
              // The fall ending the ACK is also the first low phase of the
              // read byte, so the MSB goes out right away.
              state_d  = RD_DATA;
              tx_d     = rd_val;
              sda_oe_d = ~rd_val[DL-1];
              cnt_d    = CNT_W'(1);
            end else begin
              state_d  = REG_ADDR;
              sda_oe_d = 1'b0;
            end
          end
        end

        REG_ACK, WR_ACK: begin
          if (scl_fall_e) begin
            state_d  = WR_DATA;
            cnt_d    = '0;
            sda_oe_d = 1'b0;
          end
        end

        RD_DATA: begin
          // cnt_q counts bits already placed on the bus; 0 means the
          // controller's ACK bit just ended and the next byte must be loaded.
          if (scl_fall_e) begin
            if (cnt_q == '0) begin
              tx_d     = rd_val;
              sda_oe_d = ~rd_val[DL-1];
              cnt_d    = CNT_W'(1);
            end else if (cnt_q != DATA_BITS) begin
              tx_d     = {tx_q[DL-2:0], 1'b1};
              sda_oe_d = ~tx_q[DL-2];
              cnt_d    = cnt_q + 1'b1;
            end else begin
              sda_oe_d = 1'b0;
              ptr_d    = ptr_q + 1'b1;
              cnt_d    = '0;
              state_d  = RD_ACK;
            end
          end
        end

        RD_ACK: begin
          if (scl_rise_e) begin
            cnt_d   = '0;
            state_d = sda_s2_q ? IDLE : RD_DATA;
          end
        end

        default: ;
      endcase
    end
  end

  always_ff @(posedge pclk or negedge areset) begin
    if (!areset) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      rx_q        <= '0;
      tx_q        <= '0;
      ptr_q       <= '0;
      rw_q        <= 1'b0;
      sda_oe_q    <= 1'b0;
      busy_q      <= 1'b0;
      wr_strobe_q <= 1'b0;
      wr_addr_q   <= '0;
      wr_data_q   <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      rx_q        <= rx_d;
      tx_q        <= tx_d;
      ptr_q       <= ptr_d;
      rw_q        <= rw_d;
      sda_oe_q    <= sda_oe_d;
      busy_q      <= busy_d;
      wr_strobe_q <= wr_strobe_d;
      wr_addr_q   <= wr_addr_d;
      wr_data_q   <= wr_data_d;
    end
  end

  // Register file: written only from the bus; survives START/STOP.
  always_ff @(posedge pclk or negedge areset) begin
    if (!areset) begin
      for (int i = 0; i < NO_OF_REGS; i++) begin
        regs_q[i] <= '0;
      end
    end else if (reg_we) begin
      regs_q[ptr_idx] <= rx_q[DL-1:0];
    end
  end

  // ------------------------------------------------------------------------
  // Clock stretching
  // ------------------------------------------------------------------------
`ifdef I2C_TARGET_CLOCK_STRETCH_EN
  localparam int ST_W = (STRETCH_CYCLES > 1) ? $clog2(STRETCH_CYCLES + 1) : 1;

  logic [ST_W-1:0] stretch_q, stretch_d;
  logic            ack_end;

  // SCL fall that closes an ACK bit: our own ACKs, plus the controller's ACK
  // during a read (RD_DATA with no bits sent yet).
  assign ack_end = scl_fall_e & ~start_det & ~stop_det &
                   ((state_q == ADDR_ACK) || (state_q == REG_ACK) ||
                    (state_q == WR_ACK) || (state_q == RD_DATA && cnt_q == '0));

  always_comb begin
    stretch_d = stretch_q;
    if (ack_end) begin
      stretch_d = ST_W'(STRETCH_CYCLES);
    end else if (stretch_q != '0) begin
      stretch_d = stretch_q - 1'b1;
    end
  end

  always_ff @(posedge pclk or negedge areset) begin
    if (!areset) begin
      stretch_q <= '0;
    end else begin
      stretch_q <= stretch_d;
    end
  end

  assign stretching = (stretch_q != '0);
  assign scl_oe     = stretching;
`else
  assign stretching = 1'b0;
  // Constant low; STRETCH_CYCLES only matters when stretching is built in.
  assign scl_oe     = (STRETCH_CYCLES < 0);
`endif

  assign sda_oe    = sda_oe_q;
  assign busy      = busy_q;
  assign wr_strobe = wr_strobe_q;
  assign wr_addr   = wr_addr_q;
  assign wr_data   = wr_data_q;

endmodule

// File: tb/tb_i2c_target_regfile.sv
// ---------------------------------------------------------------------------
// Bench for i2c_target_regfile: a bit-level I2C controller model on an
// open-drain bus. Expected responses go into scoreboard queues when stimulus
// is issued; monitor processes pop and compare when the DUT presents a write
// strobe or when the controller model captures an ACK / read byte / status.
// ---------------------------------------------------------------------------
module tb_i2c_target_regfile;

  localparam int Q = 8;  // pclk cycles per quarter SCL period

  logic       pclk = 1'b0;
  logic       areset = 1'b0;
  logic       m_scl_low = 1'b0;
  logic       m_sda_low = 1'b0;
  logic       sda_oe, scl_oe, busy, wr_strobe;
  logic [7:0] wr_addr, wr_data;
  logic       scl_bus, sda_bus;

  assign scl_bus = ~(m_scl_low | scl_oe);
  assign sda_bus = ~(m_sda_low | sda_oe);

  always #5 pclk = ~pclk;

  i2c_target_regfile dut (
    .pclk      (pclk),
    .areset    (areset),
    .scl_i     (scl_bus),
    .sda_i     (sda_bus),
    .sda_oe    (sda_oe),
    .scl_oe    (scl_oe),
    .busy      (busy),
    .wr_strobe (wr_strobe),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data)
  );

  int    n_checks = 0;
  int    n_pass   = 0;
  string exp_name_q[$];
  int    exp_val_q[$];
  int    obs_q[$];
  int    exp_wr_q[$];

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got 0x%0h required 0x%0h", name, act, exp);
  endtask

  // ---------------- monitors ----------------
  string mon_name;
  int    mon_exp, mon_obs;

  always @(negedge pclk) begin
    if (wr_strobe) begin
      if (exp_wr_q.size() == 0) begin
        n_checks++;
        $display("FAIL wr_strobe: unexpected strobe addr=0x%0h data=0x%0h, required none",
                 wr_addr, wr_data);
      end else begin
        mon_exp = exp_wr_q.pop_front();
        check("wr_strobe", int'({wr_addr, wr_data}), mon_exp);
      end
    end
    if (obs_q.size() > 0) begin
      mon_obs = obs_q.pop_front();
      if (exp_val_q.size() == 0) begin
        n_checks++;
        $display("FAIL scoreboard: observation 0x%0h with no expectation", mon_obs);
      end else begin
        mon_name = exp_name_q.pop_front();
        mon_exp  = exp_val_q.pop_front();
        check(mon_name, mon_obs, mon_exp);
      end
    end
  end

  int st_len = 0;
  int st_pulses = 0;
  always @(negedge pclk) begin
    if (scl_oe) st_len++;
    else if (st_len != 0) begin
`ifdef I2C_TARGET_CLOCK_STRETCH_EN
      check("stretch_len", st_len, 4);
`endif
      st_pulses++;
      st_len = 0;
    end
  end

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

  // ---------------- controller model ----------------
  task automatic tick(input int n);
    repeat (n) @(negedge pclk);
  endtask

  task automatic expect_obs(input string name, input int exp, input int act);
    exp_name_q.push_back(name);
    exp_val_q.push_back(exp);
    obs_q.push_back(act);
  endtask

  task automatic scl_release();
    m_scl_low = 1'b0;
    for (int i = 0; i < 200 && scl_bus !== 1'b1; i++) @(negedge pclk);
    if (scl_bus !== 1'b1) begin
      n_checks++;
      $display("FAIL scl_release: SCL got %b required 1 within 200 cycles", scl_bus);
    end
  endtask

  task automatic start_cond();
    m_sda_low = 1'b1; tick(Q);
    m_scl_low = 1'b1; tick(Q);
  endtask

  task automatic rstart_cond();
    m_sda_low = 1'b0; tick(Q);
    scl_release();    tick(Q);
    m_sda_low = 1'b1; tick(Q);
    m_scl_low = 1'b1; tick(Q);
  endtask

  task automatic stop_cond();
    m_sda_low = 1'b1; tick(Q);
    scl_release();    tick(Q);
    m_sda_low = 1'b0; tick(Q);
  endtask

  task automatic write_bit(input logic b);
    m_sda_low = ~b;   tick(Q);
    scl_release();    tick(2 * Q);
    m_scl_low = 1'b1; tick(Q);
  endtask

  task automatic read_bit(output logic b);
    m_sda_low = 1'b0; tick(Q);
    scl_release();    tick(Q);
    b = sda_bus;      tick(Q);
    m_scl_low = 1'b1; tick(Q);
  endtask

  // exp_ack: 0 = target ACKs, 1 = no ACK
  task automatic send_byte(input string name, input logic [7:0] b, input int exp_ack);
    logic a;
    exp_name_q.push_back(name);
    exp_val_q.push_back(exp_ack);
    for (int i = 7; i >= 0; i--) write_bit(b[i]);
    read_bit(a);
    obs_q.push_back(int'(a));
  endtask

  task automatic recv_byte(input string name, input logic [7:0] exp, input logic nack);
    logic       b;
    logic [7:0] v;
    exp_name_q.push_back(name);
    exp_val_q.push_back(int'(exp));
    v = '0;
    for (int i = 7; i >= 0; i--) begin
      read_bit(b);
      v[i] = b;
    end
    obs_q.push_back(int'(v));
    write_bit(nack);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic b;

    tick(2);
    expect_obs("rst_sda_oe",    0, int'(sda_oe));
    expect_obs("rst_scl_oe",    0, int'(scl_oe));
    expect_obs("rst_busy",      0, int'(busy));
    expect_obs("rst_wr_strobe", 0, int'(wr_strobe));
    expect_obs("rst_wr_addr",   0, int'(wr_addr));
    expect_obs("rst_wr_data",   0, int'(wr_data));
    areset = 1'b1;
    tick(4 * Q);

    // Write 0xA5, 0x5A starting at register 0x03
    exp_wr_q.push_back(16'h03A5);
    exp_wr_q.push_back(16'h045A);
    start_cond();
    expect_obs("busy_after_start", 1, int'(busy));
    send_byte("ack_addr_w", 8'hD0, 0);
    send_byte("ack_reg",    8'h03, 0);
    send_byte("ack_data0",  8'hA5, 0);
    send_byte("ack_data1",  8'h5A, 0);
    stop_cond();
    expect_obs("busy_after_stop", 0, int'(busy));
    tick(2 * Q);

    // Read back two bytes via repeated START
    start_cond();
    send_byte("ack_addr_w", 8'hD0, 0);
    send_byte("ack_reg",    8'h03, 0);
    rstart_cond();
    send_byte("ack_addr_r", 8'hD1, 0);
    recv_byte("rd_reg03", 8'hA5, 1'b0);
    recv_byte("rd_reg04", 8'h5A, 1'b1);
    expect_obs("sda_oe_after_nack", 0, int'(sda_oe));
    stop_cond();
    tick(2 * Q);

    // Wrong address: no ACK, busy held until STOP
    start_cond();
    send_byte("nack_addr_a0", 8'hA0, 1);
    expect_obs("busy_unaddressed", 1, int'(busy));
    stop_cond();
    expect_obs("busy_unaddr_stop", 0, int'(busy));
    tick(2 * Q);

    // Last register then out of range: second byte ACKed but discarded
    exp_wr_q.push_back(16'h0F11);
    start_cond();
    send_byte("ack_addr_w", 8'hD0, 0);
    send_byte("ack_reg0f",  8'h0F, 0);
    send_byte("ack_d11",    8'h11, 0);
    send_byte("ack_d22_oor", 8'h22, 0);
    stop_cond();
    tick(2 * Q);
    start_cond();
    send_byte("ack_addr_w", 8'hD0, 0);
    send_byte("ack_reg10",  8'h10, 0);
    rstart_cond();
    send_byte("ack_addr_r", 8'hD1, 0);
    recv_byte("rd_oor_ff", 8'hFF, 1'b1);
    stop_cond();
    tick(2 * Q);

    // Pointer wrap 0xFF -> 0x00
    exp_wr_q.push_back(16'h0066);
    start_cond();
    send_byte("ack_addr_w", 8'hD0, 0);
    send_byte("ack_regff",  8'hFF, 0);
    send_byte("ack_d77",    8'h77, 0);
    send_byte("ack_d66",    8'h66, 0);
    stop_cond();
    tick(2 * Q);
    start_cond();
    send_byte("ack_addr_w", 8'hD0, 0);
    send_byte("ack_reg00",  8'h00, 0);
    rstart_cond();
    send_byte("ack_addr_r", 8'hD1, 0);
    recv_byte("rd_reg00", 8'h66, 1'b0);
    recv_byte("rd_reg01", 8'h00, 1'b1);
    stop_cond();
    tick(2 * Q);

    // Reset in the middle of a read while the target pulls SDA low
    start_cond();
    send_byte("ack_addr_w", 8'hD0, 0);
    send_byte("ack_reg03",  8'h03, 0);
    rstart_cond();
    send_byte("ack_addr_r", 8'hD1, 0);
    read_bit(b);
    expect_obs("rd_bit7", 1, int'(b));
    expect_obs("sda_oe_bit6", 1, int'(sda_oe));
    areset = 1'b0;
    #1;
    expect_obs("sda_oe_async_rst", 0, int'(sda_oe));
    expect_obs("busy_async_rst",   0, int'(busy));
    tick(2);
    m_scl_low = 1'b0;
    tick(4);
    areset = 1'b1;
    tick(4 * Q);

    // Registers cleared; bus works normally afterwards
    start_cond();
    send_byte("ack_addr_w", 8'hD0, 0);
    send_byte("ack_reg03",  8'h03, 0);
    rstart_cond();
    send_byte("ack_addr_r", 8'hD1, 0);
    recv_byte("rd_cleared03", 8'h00, 1'b0);
    recv_byte("rd_cleared04", 8'h00, 1'b1);
    stop_cond();
    tick(2 * Q);
    exp_wr_q.push_back(16'h05C3);
    start_cond();
    send_byte("ack_addr_w", 8'hD0, 0);
    send_byte("ack_reg05",  8'h05, 0);
    send_byte("ack_dc3",    8'hC3, 0);
    rstart_cond();
    send_byte("ack_addr_w", 8'hD0, 0);
    send_byte("ack_reg05",  8'h05, 0);
    rstart_cond();
    send_byte("ack_addr_r", 8'hD1, 0);
    recv_byte("rd_reg05", 8'hC3, 1'b1);
    stop_cond();
    tick(4 * Q);

`ifdef I2C_TARGET_CLOCK_STRETCH_EN
    check("stretch_seen", int'(st_pulses > 0), 1);
`else
    check("scl_oe_quiet", st_pulses + st_len, 0);
`endif
    check("scb_drain", exp_val_q.size(), 0);
    check("wr_drain",  exp_wr_q.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
